matrix_mac_engine: RTL and testbench



---
 rtl/matrix_pkg.sv | 23 ++
 rtl/matrix_addr_gen.sv | 66 ++++++
 rtl/matrix_mac_engine.sv | 134 +++++++++++++
 tb/tb_matrix_mac_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared widths, FSM state encoding and issue-tag payload for the matrix
// multiply engine.
package matrix_pkg;

  localparam int unsigned MAT_ADDR_W = 12;
  localparam int unsigned MAT_AB_W   = 16;
  localparam int unsigned MAT_C_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mac_state_t;

  // Travels alongside each issued (i,j,k) triple down the read pipeline.
  typedef struct packed {
    logic                  first;
    logic                  last;
    logic [MAT_ADDR_W-1:0] c_addr;
  } mac_tag_t;

endpackage

// File: rtl/matrix_addr_gen.sv
// i/j/k loop counters (k innermost) producing registered A/B read addresses
// and the per-issue tag for the accumulate pipeline.
module matrix_addr_gen
  import matrix_pkg::*;
#(
  parameter int unsigned MAT_DIM = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_en,
  output logic [MAT_ADDR_W-1:0] a_addr,
  output logic [MAT_ADDR_W-1:0] b_addr,
  output mac_tag_t              tag,
  output logic                  tag_vld,
  output logic                  last_issue
);

  localparam int unsigned CNT_W = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAT_DIM - 1);

  logic [CNT_W-1:0] i_q;
  logic [CNT_W-1:0] j_q;
  logic [CNT_W-1:0] k_q;
  logic             k_wrap_c;
  logic             j_wrap_c;
  logic             i_wrap_c;

  assign k_wrap_c = (k_q == CNT_MAX);
  assign j_wrap_c = (j_q == CNT_MAX);
  assign i_wrap_c = (i_q == CNT_MAX);

  // N is a power of two, so i*N+k and k*N+j are plain concatenations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      a_addr     <= '0;
      b_addr     <= '0;
      tag        <= '0;
      tag_vld    <= 1'b0;
      last_issue <= 1'b0;
    end else if (issue_en) begin
      a_addr     <= MAT_ADDR_W'({i_q, k_q});
      b_addr     <= MAT_ADDR_W'({k_q, j_q});
      tag.first  <= (k_q == '0);
      tag.last   <= k_wrap_c;
      tag.c_addr <= MAT_ADDR_W'({i_q, j_q});
      tag_vld    <= 1'b1;
      last_issue <= k_wrap_c && j_wrap_c && i_wrap_c;
      k_q        <= k_wrap_c ? '0 : k_q + CNT_W'(1);
      if (k_wrap_c) begin
        j_q <= j_wrap_c ? '0 : j_q + CNT_W'(1);
        if (j_wrap_c) begin
          i_q <= i_wrap_c ? '0 : i_q + CNT_W'(1);
        end
      end
    end else begin
      a_addr     <= '0;
      b_addr     <= '0;
      tag_vld    <= 1'b0;
      last_issue <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_mac_engine.sv
// Port-B compute initiator: streams A/B reads, multiply-accumulates in 32 bits
// and writes each C element once its k loop completes.
module matrix_mac_engine
  import matrix_pkg::*;
#(
  parameter int unsigned MAT_DIM    = 64,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n_in,
  input  logic                       start_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic [2:0][MAT_ADDR_W-1:0] addrb_out,
  input  logic [1:0][MAT_AB_W-1:0]   doutb_in,
  output logic [2:2]                 web_out,
  output logic [2:2][MAT_C_W-1:0]    dinb_out
);

  localparam int unsigned LAST_STG = RD_LATENCY + 1;
  localparam logic [MAT_ADDR_W-1:0] LAST_C_ADDR = MAT_ADDR_W'(MAT_DIM * MAT_DIM - 1);

  mac_state_t                 state_q;
  logic                       issue_c;
  logic [MAT_ADDR_W-1:0]      a_addr;
  logic [MAT_ADDR_W-1:0]      b_addr;
  mac_tag_t                   tag;
  logic                       tag_vld;
  logic                       last_issue;

  logic [LAST_STG:1]          vld_q;
  mac_tag_t [LAST_STG:1]      tag_q;
  logic signed [MAT_AB_W-1:0] a_s;
  logic signed [MAT_AB_W-1:0] b_s;
  logic [MAT_C_W-1:0]         prod_c;
  logic [MAT_C_W-1:0]         prod_q;
  logic [MAT_C_W-1:0]         acc_q;
  logic [MAT_C_W-1:0]         sum_c;
  logic                       web_q;
  logic [MAT_C_W-1:0]         dinb_q;
  logic [MAT_ADDR_W-1:0]      c_addr_q;
  logic                       final_wr_c;

  assign issue_c = ((state_q == IDLE) && start_in) || ((state_q == RUN) && !last_issue);

  matrix_addr_gen #(
    .MAT_DIM (MAT_DIM)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n_in),
    .issue_en   (issue_c),
    .a_addr     (a_addr),
    .b_addr     (b_addr),
    .tag        (tag),
    .tag_vld    (tag_vld),
    .last_issue (last_issue)
  );

  // Control FSM; busy spans the first issue cycle through the DONE cycle.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            state_q  <= RUN;
            busy_out <= 1'b1;
          end
        end
        RUN: begin
          if (last_issue) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (final_wr_c) begin
            state_q  <= DONE;
            done_out <= 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          done_out <= 1'b0;
          busy_out <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_s    = doutb_in[0];
  assign b_s    = doutb_in[1];
  assign prod_c = MAT_C_W'(a_s) * MAT_C_W'(b_s);
  assign sum_c  = (tag_q[LAST_STG].first ? '0 : acc_q) + prod_q;

  // The final C write is visible on the outputs the cycle before DONE.
  assign final_wr_c = web_q && (c_addr_q == LAST_C_ADDR);

  // Tag pipeline, product register and accumulate/write stage.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q    <= '0;
      tag_q    <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      web_q    <= 1'b0;
      dinb_q   <= '0;
      c_addr_q <= '0;
    end else begin
      vld_q <= {vld_q[LAST_STG-1:1], tag_vld};
      tag_q <= {tag_q[LAST_STG-1:1], tag};
      web_q <= 1'b0;
      if (vld_q[RD_LATENCY]) begin
        prod_q <= prod_c;
      end
      if (vld_q[LAST_STG]) begin
        acc_q <= sum_c;
        if (tag_q[LAST_STG].last) begin
          web_q    <= 1'b1;
          dinb_q   <= sum_c;
          c_addr_q <= tag_q[LAST_STG].c_addr;
        end
      end
    end
  end

  assign addrb_out = {c_addr_q, b_addr, a_addr};
  assign web_out   = web_q;
  assign dinb_out  = dinb_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine at N=4 with read latencies 1 and 2,
// backed by small BRAM models and a write scoreboard.
module tb_matrix_mac_engine;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  logic             clk;
  logic             rst_n_in;
  logic             start_in;
  logic             busy1, done1, busy2, done2;
  logic [2:0][11:0] addr1, addr2;
  logic [1:0][15:0] dout1, dout2;
  logic [2:2]       web1, web2;
  logic [2:2][31:0] dinb1, dinb2;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic [15:0] rda1, rdb1, pa2, pb2, rda2, rdb2;

  exp_t q1 [$];
  exp_t q2 [$];
  int   cyc = 0;
  int   base;
  int   vectors = 0;
  int   miscompares = 0;

  matrix_mac_engine #(.MAT_DIM(4), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n_in(rst_n_in), .start_in(start_in), .busy_out(busy1),
    .done_out(done1), .addrb_out(addr1), .doutb_in(dout1), .web_out(web1),
    .dinb_out(dinb1)
  );

  matrix_mac_engine #(.MAT_DIM(4), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n_in(rst_n_in), .start_in(start_in), .busy_out(busy2),
    .done_out(done2), .addrb_out(addr2), .doutb_in(dout2), .web_out(web2),
    .dinb_out(dinb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port-B read models: one and two cycles of latency.
  always @(posedge clk) begin
    rda1 <= mem_a[addr1[0][3:0]];
    rdb1 <= mem_b[addr1[1][3:0]];
    pa2  <= mem_a[addr2[0][3:0]];
    pb2  <= mem_b[addr2[1][3:0]];
    rda2 <= pa2;
    rdb2 <= pb2;
  end
  assign dout1 = {rdb1, rda1};
  assign dout2 = {rdb2, rda2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_c(input int e);
    int      acc;
    shortint sa, sb;
    int      i, j;
    i   = e / 4;
    j   = e % 4;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      sa  = mem_a[i*4 + k];
      sb  = mem_b[k*4 + j];
      acc = acc + int'(sa) * int'(sb);
    end
    return 32'(acc);
  endfunction

  task automatic sb_check(input int which, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    int   sz;
    sz = (which == 1) ? q1.size() : q2.size();
    check($sformatf("sb%0d_pending", which), 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (which == 1) e = q1.pop_front();
      else            e = q2.pop_front();
      check($sformatf("sb%0d_addr", which), 32'(a), 32'(e.addr));
      check($sformatf("sb%0d_data", which), d, e.data);
    end
  endtask

  // mode 0: start pulse, 1: start toggled while busy, 2: start held, 3: reset at cycle 30
  task automatic run_test(input int mode, input int nruns);
    int  c, n, ea, eb;
    int  nw1, nw2, f1, f2, l1, l2, d1, d2, nd1, nd2;
    bit  stop;
    exp_t e;
    for (int r = 0; r < nruns; r++) begin
      for (int x = 0; x < 16; x++) begin
        e.addr = 12'(x);
        e.data = model_c(x);
        q1.push_back(e);
        q2.push_back(e);
      end
    end
    nw1 = 0; nw2 = 0; f1 = -1; f2 = -1; l1 = -1; l2 = -1;
    d1 = -1; d2 = -1; nd1 = 0; nd2 = 0; stop = 1'b0;
    @(posedge clk);
    #1;
    start_in = 1'b1;
    base = cyc;
    while (!stop) begin
      @(negedge clk);
      c = cyc - base;
      if (c >= 1) begin
        if (mode == 2)      start_in = (c < 71);
        else if (mode == 1) start_in = (c >= 2 && c <= 60) ? c[0] : 1'b0;
        else                start_in = 1'b0;
      end
      if (mode == 3 && c == 30) begin
        rst_n_in = 1'b0;
        #1;
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_web1", 32'(web1[2]), 32'd0);
        check("rst_addr1", 32'(addr1), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_web2", 32'(web2[2]), 32'd0);
        check("rst_addr2", 32'(addr2), 32'd0);
        stop = 1'b1;
      end else begin
        if (mode == 0 && c >= 1 && c <= 8) begin
          n  = c - 1;
          ea = (n / 16) * 4 + (n % 4);
          eb = (n % 4) * 4 + (n / 4) % 4;
          check("issue_a1", 32'(addr1[0]), 32'(ea));
          check("issue_b1", 32'(addr1[1]), 32'(eb));
          check("issue_a2", 32'(addr2[0]), 32'(ea));
          check("issue_b2", 32'(addr2[1]), 32'(eb));
        end
        if (mode == 0 && c == 66) check("drain_addr1", 32'({addr1[1], addr1[0]}), 32'd0);
        if (mode == 0 && c == 69) check("busy1_after_done", 32'(busy1), 32'd0);
        if (web1[2]) begin
          nw1++;
          if (f1 < 0) f1 = c;
          l1 = c;
          sb_check(1, addr1[2], dinb1[2]);
        end
        if (web2[2]) begin
          nw2++;
          if (f2 < 0) f2 = c;
          l2 = c;
          sb_check(2, addr2[2], dinb2[2]);
        end
        if (done1) begin
          nd1++;
          d1 = c;
          check("busy1_at_done", 32'(busy1), 32'd1);
        end
        if (done2) begin
          nd2++;
          d2 = c;
        end
        if (nd1 >= nruns && nd2 >= nruns) stop = 1'b1;
        if (c > 320) begin
          check("run_timeout", 32'd1, 32'd0);
          stop = 1'b1;
        end
      end
    end
    start_in = 1'b0;
    if (mode == 3) begin
      repeat (2) @(negedge clk);
      rst_n_in = 1'b1;
      q1.delete();
      q2.delete();
    end else begin
      check("writes1", 32'(nw1), 32'(16 * nruns));
      check("writes2", 32'(nw2), 32'(16 * nruns));
      check("dones1", 32'(nd1), 32'(nruns));
      check("sb1_empty", 32'(q1.size()), 32'd0);
      check("sb2_empty", 32'(q2.size()), 32'd0);
      if (mode == 2) begin
        check("done1_second", 32'(d1), 32'd137);
        check("done2_second", 32'(d2), 32'd139);
      end else begin
        check("first_wr1", 32'(f1), 32'd7);
        check("last_wr1", 32'(l1), 32'd67);
        check("done1_cyc", 32'(d1), 32'd68);
        check("first_wr2", 32'(f2), 32'd8);
        check("last_wr2", 32'(l2), 32'd68);
        check("done2_cyc", 32'(d2), 32'd69);
      end
    end
  endtask

  task automatic load_identity;
    for (int x = 0; x < 16; x++) begin
      mem_a[x] = ((x / 4) == (x % 4)) ? 16'd1 : 16'd0;
      mem_b[x] = 16'(x + 1);
    end
  endtask

  task automatic load_const(input logic [15:0] va, input logic [15:0] vb);
    for (int x = 0; x < 16; x++) begin
      mem_a[x] = va;
      mem_b[x] = vb;
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    start_in = 1'b0;
    load_identity();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'({busy1, busy2}), 32'd0);
    check("reset_done", 32'({done1, done2}), 32'd0);
    check("reset_addr1", 32'(addr1), 32'd0);
    check("reset_addr2", 32'(addr2), 32'd0);
    check("reset_web", 32'({web1[2], web2[2]}), 32'd0);
    check("reset_dinb1", dinb1[2], 32'd0);
    check("reset_dinb2", dinb2[2], 32'd0);
    @(negedge clk);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk);

    run_test(0, 1);
    load_const(16'h7FFF, 16'h7FFF);
    run_test(0, 1);
    load_const(16'hFFFF, 16'h0002);
    run_test(0, 1);
    load_const(16'h8000, 16'h8000);
    run_test(0, 1);
    load_identity();
    run_test(1, 1);
    repeat (3) @(negedge clk);
    run_test(2, 2);
    repeat (3) @(negedge clk);
    run_test(3, 1);
    repeat (2) @(negedge clk);
    run_test(0, 1);
    for (int x = 0; x < 16; x++) begin
      mem_a[x] = 16'($urandom);
      mem_b[x] = 16'($urandom);
    end
    run_test(0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
